// File: rtl/hazard_pkg.sv
// Shared state encoding, forward-select codes and small helpers for the hazard unit.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        LDSTALL = 2'b01,
        BRFLUSH = 2'b10,
        MEMWAIT = 2'b11
    } hz_state_t;

    typedef logic [1:0] fwd_t;

    localparam fwd_t FWD_RF  = 2'b00;
    localparam fwd_t FWD_MEM = 2'b10;
    localparam fwd_t FWD_WB  = 2'b01;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Register 0 is hard-wired to zero, so it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
        reg_match = (dst != 5'd0) && (dst == src);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] val);
        if (val == CNT_MAX) begin
            sat_inc = val;
        end else begin
            sat_inc = val + 16'd1;
        end
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline status inputs and control outputs of the hazard unit, bundled as one interface.
interface hazard_unit_if;
    import hazard_pkg::*;

    logic [4:0]  id_Rs;
    logic [4:0]  id_Rt;
    logic        id_uses_Rt;
    logic [4:0]  ex_Rs;
    logic [4:0]  ex_Rt;
    logic [4:0]  ex_Rw;
    logic        ex_RegWr;
    logic        ex_MemRd;
    logic [4:0]  mem_Rw;
    logic        mem_RegWr;
    logic [4:0]  wb_Rw;
    logic        wb_RegWr;
    logic        br_taken;
    logic        dmem_ready;

    logic        pc_stall;
    logic        ifid_stall;
    logic        freeze_all;
    logic        ifid_flush;
    logic        idex_flush;
    logic        exmem_flush;
    fwd_t        fwdA;
    fwd_t        fwdB;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    modport master (
        output id_Rs, id_Rt, id_uses_Rt, ex_Rs, ex_Rt, ex_Rw, ex_RegWr, ex_MemRd,
               mem_Rw, mem_RegWr, wb_Rw, wb_RegWr, br_taken, dmem_ready,
        input  pc_stall, ifid_stall, freeze_all, ifid_flush, idex_flush, exmem_flush,
               fwdA, fwdB, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_Rs, id_Rt, id_uses_Rt, ex_Rs, ex_Rt, ex_Rw, ex_RegWr, ex_MemRd,
               mem_Rw, mem_RegWr, wb_Rw, wb_RegWr, br_taken, dmem_ready,
        output pc_stall, ifid_stall, freeze_all, ifid_flush, idex_flush, exmem_flush,
               fwdA, fwdB, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_unit_fwd_sel.sv
// Forwarding comparator for one EX operand; the MEM-stage result wins over the WB-stage result.
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] src,
    input  logic [4:0] mem_rw,
    input  logic       mem_regwr,
    input  logic [4:0] wb_rw,
    input  logic       wb_regwr,
    output fwd_t       sel
);

    // Priority select of the youngest in-flight producer of src.
    always_comb begin
        sel = FWD_RF;
        if (mem_regwr && reg_match(mem_rw, src)) begin
            sel = FWD_MEM;
        end else if (wb_regwr && reg_match(wb_rw, src)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: forwarding, load-use stall, branch flush and memory-wait freeze.
// Statistics counters exist only when HAZARD_STATS_EN is defined; otherwise the ports read 0.
module hazard_unit
    import hazard_pkg::*;
(
    input  logic         Clk,
    input  logic         Rst_n,
    hazard_unit_if.slave bus
);

    hz_state_t state_r;
    hz_state_t state_next_s;
    logic      pending_r;
    logic      pending_next_s;

    logic      lu_hit_s;
    logic      lu_mask_s;
    logic      pc_stall_s;
    logic      ifid_stall_s;
    logic      freeze_all_s;
    logic      ifid_flush_s;
    logic      idex_flush_s;
    logic      exmem_flush_s;
    fwd_t      fwd_a_s;
    fwd_t      fwd_b_s;

    fwd_sel u_fwd_a (
        .src       (bus.ex_Rs),
        .mem_rw    (bus.mem_Rw),
        .mem_regwr (bus.mem_RegWr),
        .wb_rw     (bus.wb_Rw),
        .wb_regwr  (bus.wb_RegWr),
        .sel       (fwd_a_s)
    );

    fwd_sel u_fwd_b (
        .src       (bus.ex_Rt),
        .mem_rw    (bus.mem_Rw),
        .mem_regwr (bus.mem_RegWr),
        .wb_rw     (bus.wb_Rw),
        .wb_regwr  (bus.wb_RegWr),
        .sel       (fwd_b_s)
    );

    // ID needs no WB bypass: the register file writes on the falling edge ahead of the ID read.
    assign lu_hit_s = bus.ex_MemRd &&
                      (reg_match(bus.ex_Rw, bus.id_Rs) ||
                       (bus.id_uses_Rt && reg_match(bus.ex_Rw, bus.id_Rt)));

    // Load-use detection is blind for the one cycle following a bubble or a branch flush.
    always_comb begin
        lu_mask_s = 1'b0;
        case (state_r)
            LDSTALL: lu_mask_s = 1'b1;
            BRFLUSH: lu_mask_s = 1'b1;
            RUN:     lu_mask_s = 1'b0;
            MEMWAIT: lu_mask_s = 1'b0;
            default: lu_mask_s = 1'b0;
        endcase
    end

    // Next state and pipeline control; memory wait beats branch flush, which beats load-use.
    always_comb begin
        state_next_s   = state_r;
        pending_next_s = pending_r;
        pc_stall_s     = 1'b0;
        ifid_stall_s   = 1'b0;
        freeze_all_s   = 1'b0;
        ifid_flush_s   = 1'b0;
        idex_flush_s   = 1'b0;
        exmem_flush_s  = 1'b0;
        if (!Rst_n) begin
            state_next_s   = RUN;
            pending_next_s = 1'b0;
        end else if (!bus.dmem_ready) begin
            freeze_all_s   = 1'b1;
            pc_stall_s     = 1'b1;
            ifid_stall_s   = 1'b1;
            state_next_s   = MEMWAIT;
            pending_next_s = pending_r | bus.br_taken;
        end else begin
            pending_next_s = 1'b0;
            if (bus.br_taken || ((state_r == MEMWAIT) && pending_r)) begin
                ifid_flush_s  = 1'b1;
                idex_flush_s  = 1'b1;
                exmem_flush_s = 1'b1;
                state_next_s  = BRFLUSH;
            end else if (lu_hit_s && !lu_mask_s) begin
                pc_stall_s   = 1'b1;
                ifid_stall_s = 1'b1;
                idex_flush_s = 1'b1;
                state_next_s = LDSTALL;
            end else begin
                state_next_s = RUN;
            end
        end
    end

    // Controller state and the branch remembered across a memory wait.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_r   <= RUN;
            pending_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            pending_r <= pending_next_s;
        end
    end

    assign bus.pc_stall    = pc_stall_s;
    assign bus.ifid_stall  = ifid_stall_s;
    assign bus.freeze_all  = freeze_all_s;
    assign bus.ifid_flush  = ifid_flush_s;
    assign bus.idex_flush  = idex_flush_s;
    assign bus.exmem_flush = exmem_flush_s;
    assign bus.fwdA        = Rst_n ? fwd_a_s : FWD_RF;
    assign bus.fwdB        = Rst_n ? fwd_b_s : FWD_RF;

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt_r;
    logic [15:0] flush_cnt_r;

    // pc_stall is raised only by a load-use bubble or a memory-wait cycle; exmem_flush only by a branch.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            stall_cnt_r <= 16'h0000;
            flush_cnt_r <= 16'h0000;
        end else begin
            if (pc_stall_s) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (exmem_flush_s) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign bus.stall_cnt = stall_cnt_r;
    assign bus.flush_cnt = flush_cnt_r;
`else
    assign bus.stall_cnt = 16'h0000;
    assign bus.flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized traffic against a rule-level model.
module tb_hazard_unit;

`ifdef HAZARD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    hazard_unit_if bus ();

    hazard_unit dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h time=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- rule-level reference model ----------------
    bit m_masked  = 1'b0;
    bit m_pending = 1'b0;
    int m_stall   = 0;
    int m_flush   = 0;

    logic       e_pc, e_ifid, e_frz, e_iff, e_idf, e_exf, lu, br;
    logic [1:0] e_fa, e_fb;

    function automatic logic [1:0] model_fwd(input logic [4:0] src);
        if (bus.mem_RegWr && bus.mem_Rw != 5'd0 && bus.mem_Rw == src) return 2'b10;
        if (bus.wb_RegWr && bus.wb_Rw != 5'd0 && bus.wb_Rw == src) return 2'b01;
        return 2'b00;
    endfunction

    always @(negedge Clk) begin
        {e_pc, e_ifid, e_frz, e_iff, e_idf, e_exf} = 6'b000000;
        e_fa = 2'b00;
        e_fb = 2'b00;
        lu = bus.ex_MemRd && bus.ex_Rw != 5'd0 &&
             (bus.ex_Rw == bus.id_Rs || (bus.id_uses_Rt && bus.ex_Rw == bus.id_Rt));
        br = 1'b0;
        if (Rst_n) begin
            e_fa = model_fwd(bus.ex_Rs);
            e_fb = model_fwd(bus.ex_Rt);
            if (!bus.dmem_ready) begin
                {e_frz, e_pc, e_ifid} = 3'b111;
            end else begin
                br = bus.br_taken || m_pending;
                if (br) {e_iff, e_idf, e_exf} = 3'b111;
                else if (lu && !m_masked) {e_pc, e_ifid, e_idf} = 3'b111;
            end
        end
        cmp("pc_stall", e_pc ? 16'd1 : 16'd0, 16'(bus.pc_stall) ^ 16'(e_pc) ^ (e_pc ? 16'd1 : 16'd0));
        checks--;
        cmp("m_pc_stall",    16'(bus.pc_stall),    16'(e_pc));
        cmp("m_ifid_stall",  16'(bus.ifid_stall),  16'(e_ifid));
        cmp("m_freeze_all",  16'(bus.freeze_all),  16'(e_frz));
        cmp("m_ifid_flush",  16'(bus.ifid_flush),  16'(e_iff));
        cmp("m_idex_flush",  16'(bus.idex_flush),  16'(e_idf));
        cmp("m_exmem_flush", 16'(bus.exmem_flush), 16'(e_exf));
        cmp("m_fwdA",        16'(bus.fwdA),        16'(e_fa));
        cmp("m_fwdB",        16'(bus.fwdB),        16'(e_fb));
        cmp("m_stall_cnt",   bus.stall_cnt, STATS ? 16'(m_stall) : 16'd0);
        cmp("m_flush_cnt",   bus.flush_cnt, STATS ? 16'(m_flush) : 16'd0);
        // advance the model to the state seen after the coming rising edge
        if (!Rst_n) begin
            m_masked = 1'b0; m_pending = 1'b0; m_stall = 0; m_flush = 0;
        end else if (!bus.dmem_ready) begin
            m_pending = m_pending || bus.br_taken;
            m_masked  = 1'b0;
            if (m_stall < 65535) m_stall++;
        end else begin
            m_pending = 1'b0;
            if (br) begin
                m_masked = 1'b1;
                if (m_flush < 65535) m_flush++;
            end else if (lu && !m_masked) begin
                m_masked = 1'b1;
                if (m_stall < 65535) m_stall++;
            end else begin
                m_masked = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        bus.id_Rs = 5'd0; bus.id_Rt = 5'd0; bus.id_uses_Rt = 1'b0;
        bus.ex_Rs = 5'd0; bus.ex_Rt = 5'd0; bus.ex_Rw = 5'd0;
        bus.ex_RegWr = 1'b0; bus.ex_MemRd = 1'b0;
        bus.mem_Rw = 5'd0; bus.mem_RegWr = 1'b0;
        bus.wb_Rw = 5'd0; bus.wb_RegWr = 1'b0;
        bus.br_taken = 1'b0; bus.dmem_ready = 1'b1;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        Rst_n = 1'b0;
        idle();
        step();
        Rst_n = 1'b1;
    endtask

    task automatic load_use(input logic [4:0] r);
        bus.ex_MemRd = 1'b1; bus.ex_RegWr = 1'b1; bus.ex_Rw = r; bus.id_Rs = r;
    endtask

    // ---------------- directed scenarios then random traffic ----------------
    initial begin
        idle();
        load_use(5'd7);
        bus.br_taken = 1'b1;
        bus.dmem_ready = 1'b0;
        bus.mem_Rw = 5'd3; bus.mem_RegWr = 1'b1; bus.ex_Rs = 5'd3;
        #4;
        cmp("rst_pc_stall", 16'(bus.pc_stall), 16'd0);
        cmp("rst_freeze", 16'(bus.freeze_all), 16'd0);
        cmp("rst_exmem_flush", 16'(bus.exmem_flush), 16'd0);
        cmp("rst_fwdA", 16'(bus.fwdA), 16'd0);
        step();
        step();
        Rst_n = 1'b1;
        idle();

        // load at EX writing r10, ID reads r10
        step();
        load_use(5'd10);
        #3;
        cmp("lu_pc_stall", 16'(bus.pc_stall), 16'd1);
        cmp("lu_ifid_stall", 16'(bus.ifid_stall), 16'd1);
        cmp("lu_idex_flush", 16'(bus.idex_flush), 16'd1);
        step();
        #3;
        cmp("ldstall_pc_stall", 16'(bus.pc_stall), 16'd0);
        cmp("ldstall_idex_flush", 16'(bus.idex_flush), 16'd0);
        step();
        idle();

        // forwarding priority
        bus.mem_Rw = 5'd11; bus.mem_RegWr = 1'b1;
        bus.wb_Rw = 5'd11; bus.wb_RegWr = 1'b1;
        bus.ex_Rs = 5'd11; bus.ex_Rt = 5'd11;
        #3;
        cmp("fwdA_mem", 16'(bus.fwdA), 16'h0002);
        cmp("fwdB_mem", 16'(bus.fwdB), 16'h0002);
        bus.mem_RegWr = 1'b0;
        #1;
        cmp("fwdA_wb", 16'(bus.fwdA), 16'h0001);
        bus.ex_Rs = 5'd0;
        #1;
        cmp("fwdA_r0", 16'(bus.fwdA), 16'h0000);

        // branch together with load-use on r20
        do_reset();
        bus.ex_MemRd = 1'b1; bus.ex_RegWr = 1'b1; bus.ex_Rw = 5'd20;
        bus.id_Rt = 5'd20; bus.id_uses_Rt = 1'b1; bus.br_taken = 1'b1;
        #3;
        cmp("br_ifid_flush", 16'(bus.ifid_flush), 16'd1);
        cmp("br_idex_flush", 16'(bus.idex_flush), 16'd1);
        cmp("br_exmem_flush", 16'(bus.exmem_flush), 16'd1);
        cmp("br_pc_stall", 16'(bus.pc_stall), 16'd0);
        cmp("br_flush_cnt0", bus.flush_cnt, 16'd0);
        step();
        bus.br_taken = 1'b0;
        #3;
        cmp("brflush_masked", 16'(bus.pc_stall), 16'd0);
        cmp("br_flush_cnt1", bus.flush_cnt, STATS ? 16'd1 : 16'd0);

        // three-cycle memory wait with a branch in the first
        do_reset();
        bus.dmem_ready = 1'b0; bus.br_taken = 1'b1;
        #3;
        cmp("mw1_freeze", 16'(bus.freeze_all), 16'd1);
        cmp("mw1_exmem_flush", 16'(bus.exmem_flush), 16'd0);
        step();
        bus.br_taken = 1'b0;
        #3;
        cmp("mw2_freeze", 16'(bus.freeze_all), 16'd1);
        step();
        #3;
        cmp("mw3_freeze", 16'(bus.freeze_all), 16'd1);
        step();
        bus.dmem_ready = 1'b1;
        #3;
        cmp("mw_ready_freeze", 16'(bus.freeze_all), 16'd0);
        cmp("mw_ready_ifid_flush", 16'(bus.ifid_flush), 16'd1);
        cmp("mw_ready_exmem_flush", 16'(bus.exmem_flush), 16'd1);
        cmp("mw_stall_cnt", bus.stall_cnt, STATS ? 16'd3 : 16'd0);

        // reset while in BRFLUSH
        step();
        Rst_n = 1'b0;
        bus.br_taken = 1'b1;
        #3;
        cmp("rstbr_ifid_flush", 16'(bus.ifid_flush), 16'd0);
        cmp("rstbr_pc_stall", 16'(bus.pc_stall), 16'd0);
        step();
        Rst_n = 1'b1;
        idle();
        load_use(5'd5);
        #3;
        cmp("rstbr_run_lu", 16'(bus.pc_stall), 16'd1);
        cmp("rstbr_stall_cnt", bus.stall_cnt, 16'd0);
        cmp("rstbr_flush_cnt", bus.flush_cnt, 16'd0);

        // reset discards a branch latched during a memory wait
        step();
        idle();
        step();
        bus.dmem_ready = 1'b0; bus.br_taken = 1'b1;
        step();
        bus.br_taken = 1'b0;
        Rst_n = 1'b0;
        step();
        Rst_n = 1'b1;
        idle();
        #3;
        cmp("pend_discard", 16'(bus.exmem_flush), 16'd0);

        // random traffic with a narrow register range to force collisions
        for (int i = 0; i < 3000; i++) begin
            step();
            Rst_n          = ($urandom_range(0, 49) != 0);
            bus.id_Rs      = 5'($urandom_range(0, 3));
            bus.id_Rt      = 5'($urandom_range(0, 3));
            bus.id_uses_Rt = 1'($urandom);
            bus.ex_Rs      = 5'($urandom_range(0, 3));
            bus.ex_Rt      = 5'($urandom_range(0, 3));
            bus.ex_Rw      = 5'($urandom_range(0, 3));
            bus.ex_RegWr   = 1'($urandom);
            bus.ex_MemRd   = ($urandom_range(0, 2) == 0);
            bus.mem_Rw     = 5'($urandom_range(0, 3));
            bus.mem_RegWr  = 1'($urandom);
            bus.wb_Rw      = 5'($urandom_range(0, 3));
            bus.wb_RegWr   = 1'($urandom);
            bus.br_taken   = ($urandom_range(0, 9) == 0);
            bus.dmem_ready = ($urandom_range(0, 6) != 0);
        end

`ifdef HAZARD_STATS_EN
        // drive stall_cnt to FFFE with wait cycles, then three load-use bubbles
        do_reset();
        bus.dmem_ready = 1'b0;
        repeat (65534) step();
        idle();
        #3;
        cmp("sat_pre", bus.stall_cnt, 16'hFFFE);
        for (int k = 0; k < 3; k++) begin
            step();
            load_use(5'd9);
            step();
            idle();
        end
        #3;
        cmp("sat_hold", bus.stall_cnt, 16'hFFFF);
`endif

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
